// File: rtl/sha256_block_engine.sv
// SHA-256 compression engine: one 512-bit block per start, RPC rounds per clock.
// h_in/h_out word 0 (A) and block word 0 (W0) occupy the most significant 32 bits.
module sha256_block_engine #(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic         use_iv,
  input  logic         pad256,
  input  logic [255:0] h_in,
  input  logic [511:0] block,
  output logic         busy,
  output logic         done,
  output logic [255:0] h_out
);
  localparam int NUM_ROUND_CYC = 64 / RPC;
  localparam logic [5:0] LAST_CYC = 6'(NUM_ROUND_CYC - 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_ROUND = 2'd1, S_FINAL = 2'd2;
  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
    $error("sha256_block_engine: RPC must be 1, 2, 4 or 8");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  logic [1:0]   state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic [255:0] h_out_q, h_out_d;
  logic [31:0]  chain_q [8], chain_d [8];
  logic [31:0]  var_q [8], var_d [8];
  logic [31:0]  w_q [16], w_d [16];
  logic         load, round_en;
  logic [31:0]  rnd_var [8];
  logic [31:0]  rnd_win [16];
  logic [31:0]  t1, t2, w_new;
  logic [5:0]   rnd_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      h_out_q <= 256'd0;
      for (int i = 0; i < 8; i++) begin
        chain_q[i] <= 32'd0;
        var_q[i]   <= 32'd0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      h_out_q <= h_out_d;
      chain_q <= chain_d;
      var_q   <= var_d;
      w_q     <= w_d;
    end
  end

  // Abort takes priority over everything, including a start seen while idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !abort) state_d = S_ROUND; else state_d = S_IDLE;
      S_ROUND: if (abort) state_d = S_IDLE; else if (cnt_q == LAST_CYC) state_d = S_FINAL; else state_d = S_ROUND;
      S_FINAL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_q == S_FINAL) && !abort;
    load     = (state_q == S_IDLE) && start && !abort;
    round_en = (state_q == S_ROUND) && !abort;
  end

  // RPC chained rounds; the window slides one word per round.
  always_comb begin
    rnd_var = var_q;
    rnd_win = w_q;
    t1      = 32'd0;
    t2      = 32'd0;
    w_new   = 32'd0;
    rnd_idx = 6'd0;
    for (int r = 0; r < RPC; r++) begin
      rnd_idx = cnt_q * 6'(RPC) + 6'(r);
      t1 = rnd_var[7] + big_sigma1(rnd_var[4]) + ((rnd_var[4] & rnd_var[5]) ^ (~rnd_var[4] & rnd_var[6]))
         + K[rnd_idx] + rnd_win[0];
      t2 = big_sigma0(rnd_var[0]) + ((rnd_var[0] & rnd_var[1]) ^ (rnd_var[0] & rnd_var[2]) ^ (rnd_var[1] & rnd_var[2]));
      w_new = small_sigma1(rnd_win[14]) + rnd_win[9] + small_sigma0(rnd_win[1]) + rnd_win[0];
      for (int i = 7; i > 0; i--) rnd_var[i] = rnd_var[i-1];
      rnd_var[4] = rnd_var[4] + t1;
      rnd_var[0] = t1 + t2;
      for (int i = 0; i < 15; i++) rnd_win[i] = rnd_win[i+1];
      rnd_win[15] = w_new;
    end
  end

  always_comb begin
    chain_d = chain_q;
    var_d   = var_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    h_out_d = h_out_q;
    if (load) begin
      for (int i = 0; i < 8; i++) begin
        chain_d[i] = use_iv ? IV[i] : h_in[255-32*i -: 32];
        var_d[i]   = use_iv ? IV[i] : h_in[255-32*i -: 32];
      end
      for (int i = 0; i < 16; i++) begin
        if (pad256 && i >= 8) begin
          if (i == 8) w_d[i] = 32'h8000_0000;
          else if (i == 15) w_d[i] = 32'h0000_0100;
          else w_d[i] = 32'h0;
        end else begin
          w_d[i] = block[511-32*i -: 32];
        end
      end
      cnt_d = 6'd0;
    end else if (round_en) begin
      var_d = rnd_var;
      w_d   = rnd_win;
      cnt_d = cnt_q + 6'd1;
    end else begin
      cnt_d = 6'd0;
    end
    if (done_d) begin
      for (int i = 0; i < 8; i++) h_out_d[255-32*i -: 32] = chain_q[i] + var_q[i];
    end else begin
      h_out_d = h_out_q;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign h_out = h_out_q;
endmodule

// File: tb/tb_sha256_block_engine.sv
// Scoreboard bench for sha256_block_engine: four lanes at RPC 1/2/4/8 checked against
// a textbook 64-word-schedule SHA-256 compression model.
module tb_sha256_block_engine;
  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIG   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] ABC_BLK   = {32'h6162_6380, 448'h0, 32'h0000_0018};
  localparam logic [511:0] EMPTY_BLK = {32'h8000_0000, 480'h0};
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct packed {
    logic [255:0] dig;
    int unsigned  due;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   start_v, abort_v;
  logic         use_iv, pad256;
  logic [255:0] h_in;
  logic [511:0] block;
  logic         busy_v [4];
  logic         done_v [4];
  logic [255:0] h_out_v [4];

  exp_t         exp_q [4][$];
  int           n_cmp = 0, n_bad = 0;
  int unsigned  cyc = 0;
  int           busy_run [4];
  logic [255:0] prev0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    sha256_block_engine #(.RPC(1 << g)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start_v[g]), .abort(abort_v[g]),
      .use_iv(use_iv), .pad256(pad256), .h_in(h_in), .block(block),
      .busy(busy_v[g]), .done(done_v[g]), .h_out(h_out_v[g]));
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_hash(input logic [255:0] chain, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hc [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 8; i++) hc[i] = chain[255-32*i -: 32];
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    a = hc[0]; b = hc[1]; c = hc[2]; d = hc[3]; e = hc[4]; f = hc[5]; g = hc[6]; h = hc[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + w[i];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hc[0] + a, hc[1] + b, hc[2] + c, hc[3] + d, hc[4] + e, hc[5] + f, hc[6] + g, hc[7] + h};
  endfunction

  function automatic logic [511:0] padblk(input logic [511:0] b);
    return {b[511:256], 32'h8000_0000, 192'h0, 32'h0000_0100};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic scramble();
    logic [511:0] r;
    r = rand512();
    use_iv = 1'($urandom());
    pad256 = 1'($urandom());
    h_in   = r[255:0];
    block  = rand512();
  endtask

  // Drive one start (possibly several lanes) at a negedge and enqueue the expected result.
  task automatic issue(input logic [3:0] mask, input logic iv, input logic pd,
                       input logic [255:0] h, input logic [511:0] b, input logic [255:0] dig);
    exp_t e;
    use_iv = iv; pad256 = pd; h_in = h; block = b;
    for (int l = 0; l < 4; l++) begin
      if (mask[l]) begin
        e.dig = dig;
        e.due = cyc + (64 >> l) + 2;
        exp_q[l].push_back(e);
      end
    end
    start_v = mask;
    @(negedge clk);
    start_v = 4'b0;
  endtask

  task automatic to_cyc(input int unsigned t);
    while (cyc < t) begin
      @(negedge clk);
      scramble();
    end
  endtask

  task automatic wait_idle(input logic [3:0] mask);
    int pending;
    for (int k = 0; k < 300; k++) begin
      pending = 0;
      for (int l = 0; l < 4; l++) if (mask[l]) pending += exp_q[l].size();
      if (pending == 0) return;
      @(negedge clk);
      scramble();
    end
    n_cmp++; n_bad++;
    $display("FAIL wait_idle_timeout: lanes %b still pending after 300 cycles", mask);
  endtask

  // Monitor: pops the scoreboard whenever a lane presents done.
  initial begin : monitor
    exp_t e;
    for (int l = 0; l < 4; l++) busy_run[l] = 0;
    forever begin
      @(negedge clk);
      for (int l = 0; l < 4; l++) begin
        if (done_v[l]) begin
          if (exp_q[l].size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done lane%0d: got done=1 h_out=%h required no done", l, h_out_v[l]);
          end else begin
            e = exp_q[l].pop_front();
            chk($sformatf("digest_lane%0d", l), h_out_v[l], e.dig);
            chk($sformatf("latency_lane%0d", l), 256'(cyc), 256'(e.due));
            chk($sformatf("busy_in_done_lane%0d", l), 256'(busy_v[l]), 256'd0);
            chk($sformatf("busy_span_lane%0d", l), 256'(busy_run[l]), 256'((64 >> l) + 1));
          end
          busy_run[l] = 0;
        end else if (busy_v[l]) begin
          busy_run[l]++;
        end else begin
          busy_run[l] = 0;
        end
      end
    end
  end

  initial begin : stimulus
    int unsigned c0;
    logic [511:0] b1, b2, pb, rb;
    logic [255:0] mid, pdig, rh;
    logic riv, rpd;
    reset_n = 1'b0; start_v = 4'b0; abort_v = 4'b0;
    use_iv = 1'b0; pad256 = 1'b0; h_in = 256'd0; block = 512'd0;
    repeat (3) @(negedge clk);
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("reset_busy_lane%0d", l), 256'(busy_v[l]), 256'd0);
      chk($sformatf("reset_done_lane%0d", l), 256'(done_v[l]), 256'd0);
      chk($sformatf("reset_hout_lane%0d", l), h_out_v[l], 256'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    issue(4'b0001, 1'b1, 1'b0, 256'd0, ABC_BLK, ABC_DIG);
    wait_idle(4'b0001);
    prev0 = ABC_DIG;

    issue(4'b1111, 1'b1, 1'b0, 256'd0, EMPTY_BLK, EMPTY_DIG);
    wait_idle(4'b1111);
    prev0 = EMPTY_DIG;

    // Two-block message, second block started in the first block's done cycle.
    b1 = 512'd0;
    for (int i = 0; i < 14; i++) begin
      logic [7:0] ch;
      ch = 8'h61 + 8'(i);
      b1[511-32*i -: 32] = {ch, ch + 8'd1, ch + 8'd2, ch + 8'd3};
    end
    b1[63:32] = 32'h8000_0000;
    b2 = {480'h0, 32'h0000_01c0};
    mid = ref_hash(IV256, b1);
    c0 = cyc;
    issue(4'b0001, 1'b1, 1'b0, 256'd0, b1, mid);
    to_cyc(c0 + 66);
    chk("b2b_done_cycle", 256'(done_v[0]), 256'd1);
    issue(4'b0001, 1'b0, 1'b0, mid, b2, TWO_DIG);
    wait_idle(4'b0001);
    prev0 = TWO_DIG;

    // pad256 against the explicitly padded block, on RPC=1 and RPC=8.
    rb = rand512();
    b1 = {ABC_DIG, rb[255:0]};
    pb = padblk(b1);
    pdig = ref_hash(IV256, pb);
    issue(4'b1001, 1'b1, 1'b1, 256'd0, b1, pdig);
    wait_idle(4'b1001);
    issue(4'b1001, 1'b1, 1'b0, 256'd0, pb, pdig);
    wait_idle(4'b1001);
    prev0 = pdig;

    // Stray starts while busy, then abort at round cycle 30.
    c0 = cyc;
    issue(4'b0001, 1'b1, 1'b0, 256'd0, ABC_BLK, ABC_DIG);
    to_cyc(c0 + 5);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("stray_start_busy", 256'(busy_v[0]), 256'd1);
    to_cyc(c0 + 31);
    abort_v[0] = 1'b1;
    void'(exp_q[0].pop_back());
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("abort_busy", 256'(busy_v[0]), 256'd0);
    chk("abort_done", 256'(done_v[0]), 256'd0);
    chk("abort_hout_held", h_out_v[0], prev0);
    repeat (70) @(negedge clk);
    chk("abort_hout_later", h_out_v[0], prev0);
    issue(4'b0001, 1'b1, 1'b0, 256'd0, ABC_BLK, ABC_DIG);
    wait_idle(4'b0001);
    prev0 = ABC_DIG;

    // abort together with start while idle: start is dropped.
    start_v[0] = 1'b1; abort_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; abort_v[0] = 1'b0;
    chk("abort_start_idle_busy", 256'(busy_v[0]), 256'd0);
    repeat (70) @(negedge clk);
    chk("abort_idle_hout", h_out_v[0], prev0);

    // Random chaining values, blocks and modes on every lane.
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < 3; k++) begin
        riv = 1'($urandom()); rpd = 1'($urandom());
        b1 = rand512(); rh = b1[255:0]; b1 = rand512();
        issue(4'(1 << l), riv, rpd, rh, b1, ref_hash(riv ? IV256 : rh, rpd ? padblk(b1) : b1));
        wait_idle(4'(1 << l));
      end
    end

    // Asynchronous reset mid-block, off the clock edge.
    issue(4'b1111, 1'b1, 1'b0, 256'd0, ABC_BLK, ABC_DIG);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("async_rst_busy_lane%0d", l), 256'(busy_v[l]), 256'd0);
      chk($sformatf("async_rst_hout_lane%0d", l), h_out_v[l], 256'd0);
      exp_q[l].delete();
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("post_rst_hout", h_out_v[0], 256'd0);
    issue(4'b1001, 1'b1, 1'b0, 256'd0, ABC_BLK, ABC_DIG);
    wait_idle(4'b1111);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
